// File: rtl/peak_decimator.sv
// -----------------------------------------------------------------------------
// peak_decimator
//
// Purpose:
//   Collapses a stream of (max, min) sample pairs into one (max, min) pair per
//   window of dec_ratio accepted inputs. This is the usual way to build a
//   min/max envelope for a waveform display. Each completed window produces a
//   one-cycle out_valid pulse, one cycle after the pair that completes it. The
//   result registers keep their value until the next window completes.
//
// Ports:
//   clk        in   1   single clock, rising edge
//   rst        in   1   synchronous active-high reset (highest priority)
//   in_valid   in   1   in_max/in_min carry an accepted pair this cycle
//   in_max     in   DW  unsigned upper bound of the incoming pair
//   in_min     in   DW  unsigned lower bound of the incoming pair
//   dec_ratio  in   CW  pairs per window, sampled at window open (0 acts as 1)
//   restart    in   1   drop the open window; the pair in this cycle is ignored
//   out_valid  out  1   one-cycle pulse, result registers hold a new window
//   out_max    out  DW  largest in_max seen in the completed window
//   out_min    out  DW  smallest in_min seen in the completed window
//   out_clip   out  1   window contained a full-scale pair (optional feature)
//
// Handshake: in_valid has no backpressure. Every cycle where in_valid is high
// and restart is low consumes exactly one pair. out_valid is a pulse with no
// ready. The consumer must capture the result in the cycle where out_valid is
// high, or read the held registers before the next pulse.
//
// Configuration:
//   PEAK_DEC_CLIP_EN  When defined, a sticky per-window flag records any
//                     accepted pair with in_max all-ones or in_min zero, and
//                     out_clip loads that flag when the window completes.
//                     When undefined, out_clip is tied to 0.
// -----------------------------------------------------------------------------
module peak_decimator #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_max,
    input  logic [DW-1:0] in_min,
    input  logic [CW-1:0] dec_ratio,
    input  logic          restart,
    output logic          out_valid,
    output logic [DW-1:0] out_max,
    output logic [DW-1:0] out_min,
    output logic          out_clip
);

    localparam logic ST_FIRST = 1'b0;  // next accepted pair opens a window
    localparam logic ST_ACCUM = 1'b1;  // window open, accumulating

    logic          state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [CW-1:0] ratio_q,     ratio_d;
    logic [DW-1:0] acc_max_q,   acc_max_d;
    logic [DW-1:0] acc_min_q,   acc_min_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_max_q,   out_max_d;
    logic [DW-1:0] out_min_q,   out_min_d;

    logic [CW-1:0] eff_ratio;
    logic [CW-1:0] cnt_inc;
    logic [DW-1:0] merged_max;
    logic [DW-1:0] merged_min;
    logic          win_open;    // accepted pair opens a new window
    logic          win_done;    // accepted pair completes the window

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ratio_d     = ratio_q;
        acc_max_d   = acc_max_q;
        acc_min_d   = acc_min_q;
        out_valid_d = 1'b0;
        out_max_d   = out_max_q;
        out_min_d   = out_min_q;
        win_open    = 1'b0;
        win_done    = 1'b0;

        eff_ratio  = (dec_ratio == '0) ? CW'(1) : dec_ratio;
        cnt_inc    = cnt_q + CW'(1);
        merged_max = (in_max > acc_max_q) ? in_max : acc_max_q;
        merged_min = (in_min < acc_min_q) ? in_min : acc_min_q;

        if (restart) begin
            // The pair in this cycle is dropped, and so is any completion it
            // would have caused. The held results are left untouched.
            state_d   = ST_FIRST;
            cnt_d     = '0;
            acc_max_d = '0;
            acc_min_d = '1;
        end else if (in_valid) begin
            if (state_q == ST_FIRST) begin
                win_open  = 1'b1;
                ratio_d   = eff_ratio;
                cnt_d     = CW'(1);
                acc_max_d = in_max;
                acc_min_d = in_min;
                if (eff_ratio == CW'(1)) begin
                    // A single-pair window completes in the cycle it opens.
                    win_done    = 1'b1;
                    out_valid_d = 1'b1;
                    out_max_d   = in_max;
                    out_min_d   = in_min;
                end else begin
                    state_d = ST_ACCUM;
                end
            end else begin
                cnt_d     = cnt_inc;
                acc_max_d = merged_max;
                acc_min_d = merged_min;
                if (cnt_inc == ratio_q) begin
                    win_done    = 1'b1;
                    state_d     = ST_FIRST;
                    out_valid_d = 1'b1;
                    out_max_d   = merged_max;
                    out_min_d   = merged_min;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FIRST;
            cnt_q       <= '0;
            ratio_q     <= CW'(1);
            acc_max_q   <= '0;
            acc_min_q   <= '1;
            out_valid_q <= 1'b0;
            out_max_q   <= '0;
            out_min_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ratio_q     <= ratio_d;
            acc_max_q   <= acc_max_d;
            acc_min_q   <= acc_min_d;
            out_valid_q <= out_valid_d;
            out_max_q   <= out_max_d;
            out_min_q   <= out_min_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_min   = out_min_q;

`ifdef PEAK_DEC_CLIP_EN
    logic clip_flag_q, clip_flag_d;
    logic out_clip_q,  out_clip_d;
    logic pair_clip;
    logic clip_merged;

    always_comb begin
        clip_flag_d = clip_flag_q;
        out_clip_d  = out_clip_q;
        pair_clip   = (in_max == '1) || (in_min == '0);
        // When a window opens, the flag from the previous window is ignored.
        clip_merged = (win_open ? 1'b0 : clip_flag_q) | pair_clip;

        if (restart) begin
            clip_flag_d = 1'b0;
        end else if (in_valid) begin
            if (win_done) begin
                out_clip_d  = clip_merged;
                clip_flag_d = 1'b0;
            end else begin
                clip_flag_d = clip_merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clip_flag_q <= 1'b0;
            out_clip_q  <= 1'b0;
        end else begin
            clip_flag_q <= clip_flag_d;
            out_clip_q  <= out_clip_d;
        end
    end

    assign out_clip = out_clip_q;
`else
    assign out_clip = 1'b0;
`endif

endmodule
